// File: rtl/router_xy_if.sv
// router_xy_if: flit bus bundle for router_xy.
//   master : drives in_push, in_data, out_full; observes in_full, in_overflow,
//            out_valid, out_data (traffic source / sink side).
//   slave  : the router itself.
// Per-port fields are packed with port p at [p*DATA_WIDTH +: DATA_WIDTH].
interface router_xy_if #(
   parameter int unsigned NUM_PORTS  = 5,
   parameter int unsigned DATA_WIDTH = 16
);
   logic [NUM_PORTS-1:0]            in_push;
   logic [NUM_PORTS*DATA_WIDTH-1:0] in_data;
   logic [NUM_PORTS-1:0]            in_full;
   logic [NUM_PORTS-1:0]            in_overflow;
   logic [NUM_PORTS-1:0]            out_valid;
   logic [NUM_PORTS*DATA_WIDTH-1:0] out_data;
   logic [NUM_PORTS-1:0]            out_full;

   modport master (
      output in_push, in_data, out_full,
      input  in_full, in_overflow, out_valid, out_data
   );

   modport slave (
      input  in_push, in_data, out_full,
      output in_full, in_overflow, out_valid, out_data
   );
endinterface

// File: rtl/router_xy.sv
// router_xy: XY-routed mesh router with per-input FIFOs and per-output
// round-robin arbitration.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : router_xy_if slave modport
//      in_push/in_data   : per-port incoming flit strobe and flit
//      in_full           : input FIFO full (registered occupancy == FIFO_DEPTH)
//      in_overflow       : sticky, a flit was pushed while full and dropped
//      out_valid/out_data: per-port one-cycle flit pulse and held flit
//      out_full          : downstream full, blocks grants to that output
// Ports: 0 local, 1 north, 2 east, 3 south, 4 west, >=5 extra local.
module router_xy #(
   parameter int unsigned NUM_PORTS   = 5,
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned COORD_WIDTH = 4,
   parameter int unsigned NODE_X      = 0,
   parameter int unsigned NODE_Y      = 0
) (
   input logic        clk,
   input logic        rst,
   router_xy_if.slave bus
);

   localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW  = PtrW + 1;
   localparam int unsigned PortW = $clog2(NUM_PORTS);

   localparam logic [COORD_WIDTH-1:0] NodeX    = COORD_WIDTH'(NODE_X);
   localparam logic [COORD_WIDTH-1:0] NodeY    = COORD_WIDTH'(NODE_Y);
   localparam logic [CntW-1:0]        DepthCnt = CntW'(FIFO_DEPTH);
   localparam logic [PortW-1:0]       LastPort = PortW'(NUM_PORTS - 1);

   logic [DATA_WIDTH-1:0] mem_q [NUM_PORTS][FIFO_DEPTH];

   logic [NUM_PORTS-1:0][PtrW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [NUM_PORTS-1:0][PtrW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [NUM_PORTS-1:0][CntW-1:0]       cnt_q, cnt_d;
   logic [NUM_PORTS-1:0]                 ovf_q, ovf_d;
   logic [NUM_PORTS-1:0][PortW-1:0]      last_q, last_d;
   logic [NUM_PORTS-1:0]                 valid_q, valid_d;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] data_q, data_d;

   logic [NUM_PORTS-1:0]                 full, push_ok, pop;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] din, head;
   // route_oh[i][o]: input i is non-empty and its head is bound for output o
   logic [NUM_PORTS-1:0][NUM_PORTS-1:0]  route_oh;
   logic [COORD_WIDTH-1:0]               dest_x, dest_y;
   int                                   idx;
   logic [PortW-1:0]                     sel;

   assign din = bus.in_data;

   // Head decode and X-then-Y route selection.
   always_comb begin
      dest_x   = '0;
      dest_y   = '0;
      head     = '0;
      route_oh = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         head[i] = mem_q[i][rd_ptr_q[i]];
         dest_x  = head[i][DATA_WIDTH-1 -: COORD_WIDTH];
         dest_y  = head[i][DATA_WIDTH-COORD_WIDTH-1 -: COORD_WIDTH];
         if (cnt_q[i] != '0) begin
            if (dest_x > NodeX)      route_oh[i][2] = 1'b1;
            else if (dest_x < NodeX) route_oh[i][4] = 1'b1;
            else if (dest_y > NodeY) route_oh[i][1] = 1'b1;
            else if (dest_y < NodeY) route_oh[i][3] = 1'b1;
            else                     route_oh[i][0] = 1'b1;
         end
      end
   end

   // Round-robin per output, searching from last_grant+1. A head routes to a
   // single output, so one input can never be popped twice in a cycle.
   always_comb begin
      pop     = '0;
      valid_d = '0;
      data_d  = data_q;
      last_d  = last_q;
      idx     = 0;
      sel     = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = int'(last_q[o]) + k;
            if (idx >= int'(NUM_PORTS)) idx = idx - int'(NUM_PORTS);
            sel = PortW'(idx);
            if (!bus.out_full[o] && !valid_d[o] && route_oh[sel][o]) begin
               valid_d[o] = 1'b1;
               data_d[o]  = head[sel];
               last_d[o]  = sel;
               pop[sel]   = 1'b1;
            end
         end
      end
   end

   // FIFO bookkeeping; a push while full is dropped even if a pop frees space.
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         full[i]     = (cnt_q[i] == DepthCnt);
         push_ok[i]  = bus.in_push[i] & ~full[i];
         wr_ptr_d[i] = wr_ptr_q[i] + PtrW'(push_ok[i]);
         rd_ptr_d[i] = rd_ptr_q[i] + PtrW'(pop[i]);
         cnt_d[i]    = cnt_q[i] + CntW'(push_ok[i]) - CntW'(pop[i]);
         ovf_d[i]    = ovf_q[i] | (bus.in_push[i] & full[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= '0;
         valid_q  <= '0;
         data_q   <= '0;
         for (int o = 0; o < NUM_PORTS; o++) last_q[o] <= LastPort;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         last_q   <= last_d;
      end
   end

   // Storage needs no reset: pointers and counts define what is valid.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (push_ok[i]) mem_q[i][wr_ptr_q[i]] <= din[i];
      end
   end

   assign bus.in_full     = full;
   assign bus.in_overflow = ovf_q;
   assign bus.out_valid   = valid_q;
   assign bus.out_data    = data_q;

endmodule

// File: tb/tb_router_xy.sv
// Bench for router_xy: directed scenarios plus randomized traffic, checked
// against a queue-based transaction model of the XY router.
module tb_router_xy;
   localparam int NP    = 5;
   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int NX    = 1;
   localparam int NY    = 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   router_xy_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus ();
   router_xy #(
      .NUM_PORTS(NP), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .COORD_WIDTH(4),
      .NODE_X(NX), .NODE_Y(NY)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   router_xy_if #(.NUM_PORTS(6), .DATA_WIDTH(32)) bus6 ();
   router_xy #(
      .NUM_PORTS(6), .DATA_WIDTH(32), .FIFO_DEPTH(4), .COORD_WIDTH(4),
      .NODE_X(2), .NODE_Y(3)
   ) dut6 (
      .clk(clk),
      .rst(rst),
      .bus(bus6)
   );

   // Reference model state
   logic [DW-1:0] mq [NP][$];
   int            lg [NP];
   logic [DW-1:0] exp_data [NP];
   logic [NP-1:0] exp_valid;
   logic [NP-1:0] exp_ovf;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int route_of(input logic [DW-1:0] f);
      int dx, dy;
      dx = int'(f[15:12]);
      dy = int'(f[11:8]);
      if (dx > NX) return 2;
      if (dx < NX) return 4;
      if (dy > NY) return 1;
      if (dy < NY) return 3;
      return 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NP; i++) begin
         mq[i].delete();
         lg[i]       = NP - 1;
         exp_data[i] = '0;
      end
      exp_valid = '0;
      exp_ovf   = '0;
   endtask

   // One clock edge of the router, in transaction terms.
   task automatic model_step(input logic [NP-1:0] push, input logic [NP*DW-1:0] data,
                             input logic [NP-1:0] ofull);
      int            sz [NP];
      logic [NP-1:0] popped;
      popped    = '0;
      exp_valid = '0;
      for (int i = 0; i < NP; i++) sz[i] = mq[i].size();
      for (int o = 0; o < NP; o++) begin
         if (!ofull[o]) begin
            for (int k = 1; k <= NP; k++) begin
               int src;
               src = (lg[o] + k) % NP;
               if (sz[src] > 0 && route_of(mq[src][0]) == o) begin
                  exp_valid[o] = 1'b1;
                  exp_data[o]  = mq[src][0];
                  lg[o]        = src;
                  popped[src]  = 1'b1;
                  break;
               end
            end
         end
      end
      for (int i = 0; i < NP; i++) begin
         if (popped[i]) void'(mq[i].pop_front());
         if (push[i]) begin
            if (sz[i] >= DEPTH) exp_ovf[i] = 1'b1;
            else mq[i].push_back(data[i*DW +: DW]);
         end
      end
   endtask

   task automatic cycle(input logic [NP-1:0] push, input logic [NP*DW-1:0] data,
                        input logic [NP-1:0] ofull);
      logic [NP-1:0] exp_full;
      bus.in_push  = push;
      bus.in_data  = data;
      bus.out_full = ofull;
      model_step(push, data, ofull);
      @(posedge clk);
      #1;
      check_eq("out_valid", 64'(bus.out_valid), 64'(exp_valid));
      for (int o = 0; o < NP; o++)
         check_eq($sformatf("out_data[%0d]", o), 64'(bus.out_data[o*DW +: DW]),
                  64'(exp_data[o]));
      for (int i = 0; i < NP; i++) exp_full[i] = (mq[i].size() == DEPTH);
      check_eq("in_full", 64'(bus.in_full), 64'(exp_full));
      check_eq("in_overflow", 64'(bus.in_overflow), 64'(exp_ovf));
      bus.in_push = '0;
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) cycle('0, '0, '0);
   endtask

   function automatic logic [NP*DW-1:0] put(input int p, input logic [DW-1:0] f,
                                           input logic [NP*DW-1:0] acc);
      logic [NP*DW-1:0] r;
      r = acc;
      r[p*DW +: DW] = f;
      return r;
   endfunction

   task automatic apply_reset();
      bus.in_push   = '0;
      bus.in_data   = '0;
      bus.out_full  = '0;
      bus6.in_push  = '0;
      bus6.in_data  = '0;
      bus6.out_full = '0;
      rst = 1'b1;
      #1;
      check_eq("rst_in_full", 64'(bus.in_full), 64'd0);
      check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("rst_in_overflow", 64'(bus.in_overflow), 64'd0);
      for (int o = 0; o < NP; o++)
         check_eq("rst_out_data", 64'(bus.out_data[o*DW +: DW]), 64'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NP*DW-1:0] d;
      logic [NP-1:0]    p, f;
      int               got;

      apply_reset();

      // Three inputs contend for east right after reset: 0, 1, 3 in turn.
      d = put(0, 16'h2A00, '0);
      d = put(1, 16'h2A01, d);
      d = put(3, 16'h2A03, d);
      cycle(5'b01011, d, '0);
      cycle('0, '0, '0);
      check_eq("rr_first", 64'(bus.out_data[2*DW +: DW]), 64'h2A00);
      cycle('0, '0, '0);
      check_eq("rr_second", 64'(bus.out_data[2*DW +: DW]), 64'h2A01);
      cycle('0, '0, '0);
      check_eq("rr_third", 64'(bus.out_data[2*DW +: DW]), 64'h2A03);
      check_eq("rr_third_valid", 64'(bus.out_valid[2]), 64'd1);
      idle(2);

      // Single flit east, one cycle of latency.
      cycle(5'b00001, put(0, 16'h2155, '0), '0);
      check_eq("lat_not_yet", 64'(bus.out_valid[2]), 64'd0);
      cycle('0, '0, '0);
      check_eq("east_valid", 64'(bus.out_valid[2]), 64'd1);
      check_eq("east_data", 64'(bus.out_data[2*DW +: DW]), 64'h2155);
      cycle('0, '0, '0);
      check_eq("east_pulse_ends", 64'(bus.out_valid[2]), 64'd0);

      // From west: local, then south.
      cycle(5'b10000, put(4, 16'h1155, '0), '0);
      cycle(5'b10000, put(4, 16'h1055, '0), '0);
      check_eq("local_data", 64'(bus.out_data[0*DW +: DW]), 64'h1155);
      cycle('0, '0, '0);
      check_eq("south_data", 64'(bus.out_data[3*DW +: DW]), 64'h1055);
      idle(2);

      // Stalled east output: fill, overflow, then drain in order.
      for (int n = 0; n < 5; n++) begin
         cycle(5'b00001, put(0, 16'(16'h2000 + n), '0), 5'b00100);
         if (n == 3) check_eq("fill_full", 64'(bus.in_full[0]), 64'd1);
      end
      check_eq("fill_overflow", 64'(bus.in_overflow[0]), 64'd1);
      got = 0;
      for (int c = 0; c < 8; c++) begin
         cycle('0, '0, '0);
         if (bus.out_valid[2]) begin
            check_eq("drain_order", 64'(bus.out_data[2*DW +: DW]), 64'(16'h2000 + got));
            got++;
         end
      end
      check_eq("drain_count", 64'(got), 64'd4);
      check_eq("overflow_sticky", 64'(bus.in_overflow[0]), 64'd1);

      // Reset mid-operation: buffered and in-flight flits are lost.
      for (int n = 0; n < 3; n++) cycle(5'b00001, put(0, 16'(16'h2100 + n), '0), 5'b10100);
      for (int n = 0; n < 4; n++) cycle(5'b01000, put(3, 16'(16'h0100 + n), '0), 5'b10100);
      cycle(5'b00010, put(1, 16'h1177, '0), 5'b10100);
      cycle('0, '0, 5'b10100);
      check_eq("pre_rst_inflight", 64'(bus.out_valid[0]), 64'd1);
      apply_reset();
      got = 0;
      for (int c = 0; c < 6; c++) begin
         cycle('0, '0, '0);
         if (bus.out_valid != '0) got++;
      end
      check_eq("post_rst_flits", 64'(got), 64'd0);

      // Six-port, 32-bit instance: flit for its own node on port 5 goes local.
      bus6.in_push = 6'b100000;
      bus6.in_data = '0;
      bus6.in_data[5*32 +: 32] = 32'h23ABCDEF;
      cycle('0, '0, '0);
      bus6.in_push = '0;
      check_eq("p6_not_yet", 64'(bus6.out_valid), 64'd0);
      cycle('0, '0, '0);
      check_eq("p6_valid", 64'(bus6.out_valid), 64'h01);
      check_eq("p6_data", 64'(bus6.out_data[31:0]), 64'h23ABCDEF);

      // Randomized traffic with random back-pressure and U-turns.
      for (int c = 0; c < 400; c++) begin
         p = NP'($urandom_range(0, 31));
         d = '0;
         for (int i = 0; i < NP; i++)
            d[i*DW +: DW] = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                             8'($urandom)};
         for (int o = 0; o < NP; o++) f[o] = ($urandom_range(0, 3) == 0);
         cycle(p, d, f);
      end
      idle(24);
      for (int i = 0; i < NP; i++)
         check_eq("model_drained", 64'(mq[i].size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/router_xy.md
ROUTER_XY -- requirements
Module: router_xy

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 5, number of ports; port 0 local, 1 north, 2 east, 3 south, 4 west; ports >=5 are extra local ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, flit width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, input buffer entries per port, power of two, >=2.
REQ-004 SHALL have parameter COORD_WIDTH, default 4, width of each destination coordinate field.
REQ-005 SHALL have parameters NODE_X and NODE_Y, default 0, this node's mesh coordinates.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port clk, input, 1, rising-edge clock.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port in_push, input, NUM_PORTS, per-port flit-present strobe.
REQ-010 SHALL have port in_data, input, NUM_PORTS*DATA_WIDTH, per-port flit; port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port in_full, output, NUM_PORTS, per-port input buffer full.
REQ-012 SHALL have port in_overflow, output, NUM_PORTS, sticky per-port dropped-flit flag.
REQ-013 SHALL have port out_valid, output, NUM_PORTS, per-port flit-sent strobe.
REQ-014 SHALL have port out_data, output, NUM_PORTS*DATA_WIDTH, per-port outgoing flit, same packing as in_data.
REQ-015 SHALL have port out_full, input, NUM_PORTS, per-port downstream buffer full.

Function
REQ-016 Flit header: dest_x = flit[DATA_WIDTH-1 -: COORD_WIDTH]; dest_y = flit[DATA_WIDTH-COORD_WIDTH-1 -: COORD_WIDTH]; both unsigned.
REQ-017 Route of head flit, X first: dest_x>NODE_X -> port 2; dest_x<NODE_X -> port 4; else dest_y>NODE_Y -> port 1; dest_y<NODE_Y -> port 3; else port 0.
REQ-018 Each input port has a FIFO_DEPTH-entry FIFO; push when in_push=1 and in_full=0 at the clock edge.
REQ-019 in_full = registered occupancy == FIFO_DEPTH; push while in_full=1 is discarded even if a pop occurs in the same cycle, and sets in_overflow[p] until reset.
REQ-020 Read/write pointers wrap modulo FIFO_DEPTH; simultaneous push and pop when not full leaves occupancy unchanged.
REQ-021 Per output o, each cycle: requesters = non-empty inputs whose head routes to o; a grant issues only if out_full[o]=0 sampled in that cycle.
REQ-022 Arbitration per output is round-robin: search starts at (last_grant[o]+1) mod NUM_PORTS; last_grant[o] updates only on a grant.
REQ-023 Each input is granted to at most one output per cycle (single head); each output grants at most one input per cycle.
REQ-024 On grant, the head flit is popped and registered into out_data[o] with out_valid[o]=1 at the next edge; out_valid[o] is a one-cycle pulse per flit.
REQ-025 With no grant, out_valid[o]=0 next cycle; out_data[o] holds its last value.
REQ-026 Latency: in_push at edge E into an empty, uncontended buffer -> out_valid at edge E+1 (visible the cycle after the push is sampled).
REQ-027 Throughput: one flit per output per cycle sustained when out_full=0 and one input targets it.
REQ-028 A flit routed to its own arrival port (U-turn) is forwarded normally.
REQ-029 out_full[o] held at 1 stalls requesting heads indefinitely without loss; head-of-line blocking applies to that input.

Reset
REQ-030 rst asynchronously clears all FIFOs to empty: in_full=0, in_overflow=0, out_valid=0, out_data=0, last_grant[o]=NUM_PORTS-1 (input 0 wins first).
REQ-031 rst mid-operation discards all buffered and in-flight flits; no out_valid pulse for them after rst deasserts.

Verification
REQ-032 Node (1,1); push 0x2155 on port 0 -> port 2 out_valid pulse one cycle later, out_data[2]=0x2155.
REQ-033 Node (1,1); push 0x1155 on port 4 -> out_data[0]=0x1155; push 0x1055 -> out_data[3]=0x1055.
REQ-034 Inputs 0,1,3 each hold one flit to port 2 simultaneously after reset -> grants in order 0,1,3 on consecutive cycles.
REQ-035 out_full[2]=1, 5 pushes to port 0 routed east, FIFO_DEPTH=4 -> in_full[0]=1 after 4, 5th dropped, in_overflow[0]=1; release -> exactly 4 flits in order.
REQ-036 Assert rst with 3 flits buffered -> in_full=0, out_valid=0 immediately; no flits emerge after release.
REQ-037 NUM_PORTS=6, DATA_WIDTH=32 instance: flit for (NODE_X,NODE_Y) pushed on port 5 -> emerges on port 0.
